// File: rtl/nibble_load_pkg.sv
// nibble_load_pkg: shared widths, FIFO depth, load-counter width and the occupancy enum for nibble_load_ctrl
package nibble_load_pkg;
  localparam int NL_WIDTH = 4;
  localparam int NL_DIV_W = 4;
  localparam int NL_FIFO_DEPTH = 2;
  localparam int NL_CNT_W = 8;
  typedef enum logic [1:0] {NL_EMPTY, NL_ONE, NL_FULL} nl_occ_t;
endpackage

// File: rtl/nibble_load_fifo.sv
// nibble_load_fifo: 2-entry FIFO; in clk/rst/push/pop/din, out head (oldest word) and occ (EMPTY/ONE/FULL); push must not be asserted when FULL, pop must not be asserted when EMPTY
module nibble_load_fifo import nibble_load_pkg::*; #(
  parameter int WIDTH = NL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output nl_occ_t          occ
);
  nl_occ_t occ_q, occ_d;
  logic [WIDTH-1:0] mem_q [NL_FIFO_DEPTH];
  logic [WIDTH-1:0] mem_d [NL_FIFO_DEPTH];
  always_comb begin
    occ_d = (push && !pop) ? (occ_q == NL_EMPTY ? NL_ONE : NL_FULL) :
            (pop && !push) ? (occ_q == NL_FULL ? NL_ONE : NL_EMPTY) : occ_q;
    mem_d[0] = (push && (occ_q == NL_EMPTY || (occ_q == NL_ONE && pop))) ? din :
               pop ? mem_q[1] : mem_q[0];
    mem_d[1] = (push && !pop && occ_q == NL_ONE) ? din : mem_q[1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= NL_EMPTY;
      mem_q <= '{default: '0};
    end else begin
      occ_q <= occ_d;
      mem_q <= mem_d;
    end
  end
  assign head = mem_q[0];
  assign occ = occ_q;
endmodule

// File: rtl/nibble_load_ctrl.sv
// nibble_load_ctrl: valid/ready nibble feeder pacing one-cycle load strobes every div+1 cycles; in clk/rst/in_valid/in_data/div, out in_ready/load_en/load_data/busy, plus 8-bit saturating load_cnt when NIBBLE_LOAD_CNT_EN is defined
module nibble_load_ctrl import nibble_load_pkg::*; #(
  parameter int WIDTH = NL_WIDTH,
  parameter int DIV_W = NL_DIV_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_data,
  input  logic [DIV_W-1:0]    div,
  output logic                load_en,
  output logic [WIDTH-1:0]    load_data,
  output logic                busy
`ifdef NIBBLE_LOAD_CNT_EN
  ,
  output logic [NL_CNT_W-1:0] load_cnt
`endif
);
  nl_occ_t occ;
  logic [WIDTH-1:0] head, load_data_q, load_data_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic load_en_q, load_en_d, push, pop, tick;
  assign in_ready = !rst && occ != NL_FULL;
  assign push = in_valid && in_ready;
  assign tick = cnt_q == '0;
  assign pop = tick && occ != NL_EMPTY;
  always_comb begin
    cnt_d = tick ? div : cnt_q - DIV_W'(1);
    load_en_d = pop;
    load_data_d = pop ? head : load_data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      load_en_q <= 1'b0;
      load_data_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      load_en_q <= load_en_d;
      load_data_q <= load_data_d;
    end
  end
  nibble_load_fifo #(.WIDTH(WIDTH)) u_fifo (
    .clk (clk),
    .rst (rst),
    .push(push),
    .pop (pop),
    .din (in_data),
    .head(head),
    .occ (occ)
  );
  assign load_en = load_en_q;
  assign load_data = load_data_q;
  assign busy = occ != NL_EMPTY || load_en_q;
`ifdef NIBBLE_LOAD_CNT_EN
  logic [NL_CNT_W-1:0] load_cnt_q, load_cnt_d;
  always_comb load_cnt_d = (load_en_q && load_cnt_q != '1) ? load_cnt_q + NL_CNT_W'(1) : load_cnt_q;
  always_ff @(posedge clk) load_cnt_q <= rst ? '0 : load_cnt_d;
  assign load_cnt = load_cnt_q;
`endif
endmodule

// File: doc/nibble_load_ctrl.md
# nibble_load_ctrl

Upstream feeder for the 4-bit clock-enabled register stage. It accepts nibbles over a valid/ready handshake and buffers them in a 2-entry FIFO. On a programmable tick it issues single-cycle load strobes (`load_en`) with data (`load_data`), which drive the downstream register's clock enable and data input directly. It paces loads so the downstream register updates at most once per `div+1` cycles.

## Interface
Parameters:
- `WIDTH`, 4: data width; matches the downstream register.
- `DIV_W`, 4: width of the tick divider.

Ports:
- `clk`, in, 1: rising-edge clock.
- `rst`, in, 1: synchronous reset, active-high.
- `in_valid`, in, 1: upstream word valid.
- `in_ready`, out, 1: FIFO can accept a word.
- `in_data`, in, `WIDTH`: upstream word.
- `div`, in, `DIV_W`: tick period minus one.
- `load_en`, out, 1: one-cycle load strobe; drives downstream `clken`.
- `load_data`, out, `WIDTH`: word to load; drives downstream `D`.
- `busy`, out, 1: FIFO non-empty or `load_en` high.
- `load_cnt`, out, 8: load counter; present only with `NIBBLE_LOAD_CNT_EN`.

## Operation
- Clock is `clk`. Reset is `rst`, synchronous and active-high. All state is updated on `posedge clk`.
- **Push.** A word is pushed when `in_valid && in_ready`.
- **Ready.** `in_ready = !rst && occupancy != 2`. It is combinational from registered occupancy. There is no pass-through when the FIFO is full.
- **Occupancy states.**
  - EMPTY, then push → ONE.
  - ONE, then push with no pop → FULL.
  - ONE, then pop with no push → EMPTY.
  - ONE, then push and pop together → ONE.
  - FULL, then pop → ONE. Push is impossible while FULL.
- **Tick counter.**
  - Down-counter of `DIV_W` bits.
  - A tick occurs when the counter is 0; the counter then reloads `div`. Otherwise it decrements.
  - The counter runs freely whether or not data is present.
  - A change to `div` takes effect at the next reload.
  - With `div=0` there is a tick every cycle.
- **Pop.**
  - On a tick with occupancy ≠ EMPTY: pop the head, register `load_data <= head`, and set `load_en <= 1`.
  - Otherwise `load_en <= 0`, and `load_data` holds its last value.
- **Reset values** (in effect from the cycle after `rst` is sampled high):
  - `load_en` = 0, `load_data` = 0, occupancy EMPTY.
  - Tick counter = 0, so the first cycle after reset is a tick.
  - `busy` = 0, `load_cnt` = 0.
- **Reset mid-operation.** Buffered words are discarded and never emitted. A strobe that was pending for the next cycle is cancelled.
- **Busy.** `busy = (occupancy != EMPTY) || load_en`.

## Timing
- Push at cycle N makes the word the head at N+1.
- Earliest `load_en` is at N+2: this requires a tick at N+1 and the word at the head.
- A tick at cycle T with a non-empty FIFO gives `load_en` = 1 at T+1 for exactly one cycle. The downstream register captures the word at the end of T+1.
- Minimum spacing of `load_en` pulses is `div+1` cycles. With `div=0`, full throughput is one word per cycle with no bubbles once the FIFO is primed.
- `in_ready` responds in the same cycle to occupancy changes registered on the previous edge.

## Configuration
- Macro: `NIBBLE_LOAD_CNT_EN`.
- **Defined:**
  - The `load_cnt` port exists.
  - It is an 8-bit counter incremented on each cycle where `load_en` is 1.
  - It saturates at 255 and clears only on `rst`.
- **Undefined:** the port and the counter logic are absent. All other behaviour is identical.

## Structure
- Package `nibble_load_pkg` holds:
  - `NL_WIDTH` = 4
  - `NL_DIV_W` = 4
  - `NL_FIFO_DEPTH` = 2
  - `NL_CNT_W` = 8
  - enum `nl_occ_t` {`NL_EMPTY`, `NL_ONE`, `NL_FULL`}
- Sub-module `nibble_load_fifo`: the 2-entry FIFO with push/pop, head output, occupancy state, and synchronous reset.
- The tick counter, strobe register, and optional load counter live in the top level.

## Test plan
1. **Single word, slow tick.** `div=3`, `rst` released at cycle 0, push `0xA` at cycle 1.
   - Ticks occur at cycles 0, 4, 8.
   - `load_en` = 1 only at cycle 5 with `load_data` = `0xA`.
   - `busy` falls at cycle 6.
2. **Full throughput.** `div=0`, push `0x1`, `0x2`, `0x3` back-to-back from cycle 1.
   - `in_ready` stays 1.
   - `load_en` is high at cycles 3, 4, 5 with data 1, 2, 3.
3. **Backpressure.** `div=7`, `in_valid` held high with words 5, 6, 7 starting at cycle 1.
   - `in_ready` drops to 0 after two accepts.
   - Word 7 is accepted only after the first pop.
   - Loads appear at cycles 9, 17, 25 with 5, 6, 7.
4. **Reset mid-operation.** FIFO FULL with `0xC`, `0xD`; assert `rst` for one cycle.
   - Next cycle: `load_en` = 0, `load_data` = 0, `busy` = 0, `in_ready` = 1.
   - Neither `0xC` nor `0xD` is ever emitted.
5. **Divider change.** `div` changed from 3 to 1 mid-count.
   - The current period completes at 4 cycles; subsequent ticks are every 2 cycles.
6. **Load counter** (`NIBBLE_LOAD_CNT_EN`). `div=0`, 300 words streamed.
   - `load_cnt` reads 255 and holds; `rst` returns it to 0.
